// File: rtl/d8_fetch.sv
// d8_fetch: PC owner and instruction-memory initiator with a 2-entry in-order output buffer.
// Define D8_FETCH_ALIGN_CHECK_EN to halt with err=1 on a misaligned redirect target.
module d8_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic        mem_en,
  output logic [7:0]  mem_adr,
  input  logic [31:0] mem_dout,
  input  logic        jmp,
  input  logic [7:0]  jmp_adr,
  output logic [31:0] inst,
  output logic [7:0]  inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        err
);
  localparam int DEPTH = 2;

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  pc_reg, pc_next;
  logic [7:0]  req_pc_reg;
  logic        inflight_reg;
  logic [1:0]  count_reg, count_next;
  logic [39:0] slot_reg [DEPTH];
  logic [39:0] slot_next [DEPTH];

  logic        run, pop, pop_eff, push, issue, flush;
  logic [2:0]  occupancy;
  logic [1:0]  tail_idx;
  logic [7:0]  jmp_target;

`ifdef D8_FETCH_ALIGN_CHECK_EN
  logic err_reg, err_next;
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg <= RUN;
`ifdef D8_FETCH_ALIGN_CHECK_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
`ifdef D8_FETCH_ALIGN_CHECK_EN
      err_reg   <= err_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
`ifdef D8_FETCH_ALIGN_CHECK_EN
    jmp_target = jmp_adr;
    err_next   = err_reg;
    if (state_reg == RUN && jmp && jmp_adr[1:0] != 2'b00) begin
      state_next = HALT;
      err_next   = 1'b1;
    end
`else
    jmp_target = jmp_adr & 8'hFC;
`endif
  end

  assign run        = (state_reg == RUN);
  assign inst_valid = (count_reg != 2'd0);
  assign inst       = slot_reg[0][39:8];
  assign inst_pc    = slot_reg[0][7:0];

  // A redirect (or halt) discards both buffered words and the in-flight response.
  assign flush     = jmp | ~run;
  assign pop       = inst_valid & inst_ready;
  assign pop_eff   = pop & ~flush;
  assign push      = inflight_reg & ~flush;
  assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue     = run & ~jmp & ~sys_rst & (occupancy < 3'd2);
  assign mem_en    = issue;
  assign mem_adr   = pc_reg;

  assign tail_idx   = count_reg - {1'b0, pop_eff};
  assign count_next = flush ? 2'd0 : (count_reg + {1'b0, push} - {1'b0, pop_eff});

  always_comb begin
    pc_next = pc_reg;
    if (jmp && run) begin
      pc_next = jmp_target;
    end else if (issue) begin
      pc_next = pc_reg + 8'd4;
    end
  end

  // Shift-down FIFO: a pop moves each slot toward the head, a push lands just behind the survivors.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [39:0] above;
    if (gi < DEPTH - 1) begin : g_mid
      assign above = slot_reg[gi+1];
    end else begin : g_top
      assign above = '0;
    end
    assign slot_next[gi] = (push && tail_idx == 2'(gi)) ? {mem_dout, req_pc_reg} :
                           pop_eff                      ? above :
                                                          slot_reg[gi];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pc_reg       <= RESET_PC;
      req_pc_reg   <= 8'h00;
      inflight_reg <= 1'b0;
      count_reg    <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_reg[i] <= '0;
      end
    end else begin
      pc_reg       <= pc_next;
      inflight_reg <= issue;
      count_reg    <= count_next;
      if (issue) begin
        req_pc_reg <= pc_reg;
      end
      for (int i = 0; i < DEPTH; i++) begin
        slot_reg[i] <= slot_next[i];
      end
    end
  end

endmodule
